// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the PC and fetches one instruction at a time
// from instruction memory, with at most one memory request outstanding. Each
// fetched instruction is offered to decode over a valid/ready handshake.
//
// A redirect from the branch resolver flushes any in-flight or held
// instruction and restarts fetch at the new address. A response that belongs
// to a request issued before the redirect is discarded in the DROP state.
//
// Build option: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect target with addr[1:0] != 0 is loaded as-is and
//               parks the unit in FAULT (misalign_fault=1, no fetching)
//               until an aligned redirect arrives. If a request is still
//               outstanding, its response is drained before FAULT.
//   undefined : the low two PC bits are forced to zero on every load,
//               misalign_fault is tied low and there is no FAULT state.
//
// Parameters
//   ADDR_W    PC / memory address width
//   DATA_W    instruction width
//   RESET_PC  PC loaded on reset
//
// Ports
//   clk            in   rising-edge clock
//   nrst           in   asynchronous reset, active low
//   redirect_en    in   redirect fetch this cycle
//   redirect_addr  in   redirect target
//   imem_req       out  request valid to instruction memory
//   imem_addr      out  request address (the current PC)
//   imem_gnt       in   memory accepts the request this cycle
//   imem_rvalid    in   response valid (earliest the cycle after the grant)
//   imem_rdata     in   response instruction
//   inst_valid     out  instruction valid to decode
//   inst           out  fetched instruction
//   inst_pc        out  PC of inst
//   inst_ready     in   decode accepts the instruction
//   misalign_fault out  misaligned redirect target seen (option only)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic              misalign_fault
);

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_WAIT,
      ST_HOLD,
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT,
`endif
      ST_DROP
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redirect_pc;
   state_t            restart_state;

   // Sequential PC advance; wraps naturally at the top of the address space.
   assign pc_plus4 = pc_q + ADDR_W'(4);

   // redirect_pc is what a redirect loads into the PC; restart_state is where
   // a redirect goes when no memory response is left to drain.
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] RESET_PC_LOAD = RESET_PC;

   logic redirect_bad;
   logic fault_pend_q, fault_pend_d;

   assign redirect_bad  = (redirect_addr[1:0] != 2'b00);
   assign redirect_pc   = redirect_addr;
   assign restart_state = redirect_bad ? ST_FAULT : ST_FETCH;
`else
   localparam logic [ADDR_W-1:0] RESET_PC_LOAD = RESET_PC & ~ADDR_W'(3);

   assign redirect_pc   = redirect_addr & ~ADDR_W'(3);
   assign restart_state = ST_FETCH;
`endif

   // State, PC and the held instruction. Reset puts the unit in FETCH at the
   // reset PC with nothing held.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC_LOAD;
         inst_q    <= '0;
         inst_pc_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         fault_pend_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         fault_pend_q <= fault_pend_d;
`endif
      end
   end

   // Next-state logic. A redirect always updates the PC; the state it leads
   // to depends on whether a granted request still owes a response (DROP
   // swallows that response before fetching again). In DROP the latest
   // redirect wins. fault_pend remembers whether the drained DROP should end
   // in FAULT rather than FETCH.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_d = fault_pend_q;
`endif
      case (state_q)
         ST_FETCH: begin
            if (redirect_en) begin
               pc_d = redirect_pc;
               if (imem_gnt) begin
                  state_d = ST_DROP;
`ifdef FETCH_MISALIGN_CHECK_EN
                  fault_pend_d = redirect_bad;
`endif
               end else begin
                  state_d = restart_state;
               end
            end else if (imem_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_en) begin
               pc_d = redirect_pc;
               if (imem_rvalid) begin
                  state_d = restart_state;
               end else begin
                  state_d = ST_DROP;
`ifdef FETCH_MISALIGN_CHECK_EN
                  fault_pend_d = redirect_bad;
`endif
               end
            end else if (imem_rvalid) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               pc_d      = pc_plus4;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_en) begin
               pc_d    = redirect_pc;
               state_d = restart_state;
            end else if (inst_ready) begin
               state_d = ST_FETCH;
            end
         end
         ST_DROP: begin
            if (redirect_en) begin
               pc_d = redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
               fault_pend_d = redirect_bad;
`endif
            end
            if (imem_rvalid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
               if (redirect_en) begin
                  state_d = restart_state;
               end else begin
                  state_d = fault_pend_q ? ST_FAULT : ST_FETCH;
               end
`else
               state_d = ST_FETCH;
`endif
            end
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         ST_FAULT: begin
            if (redirect_en) begin
               pc_d    = redirect_pc;
               state_d = restart_state;
            end
         end
`endif
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Outputs come straight from registers. The request is additionally
   // masked by reset so memory sees no request while the unit is held.
   assign imem_req   = nrst && (state_q == ST_FETCH);
   assign imem_addr  = pc_q;
   assign inst_valid = (state_q == ST_HOLD);
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign_fault = (state_q == ST_FAULT);
`else
   assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A small memory responder answers every accepted
// request after a programmable delay with data derived from the address.
// The main sequence pushes the (pc, instruction) pairs decode should receive
// onto a scoreboard queue; a monitor pops and compares one entry on every
// handshake. A second instance with RESET_PC = 0xFFFF_FFFC shares the inputs
// and exercises the PC wrap out of reset.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        misalign_fault;

   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic        w_inst_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_misalign_fault;

   int check_count = 0;
   int error_count = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int          resp_delay = 0;
   int          spur_req = 0;
   int          spur_ack = 0;
   logic        acc_now = 1'b0;
   logic [31:0] acc_addr = '0;
   logic        pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   logic [31:0] w_addr_log[2];
   int          w_log_cnt = 0;
   logic [31:0] w_first_pc = '0;
   logic [31:0] w_first_inst = '0;
   logic        w_first_seen = 1'b0;
   logic        w_fault_seen = 1'b0;

   fetch_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .inst_ready    (inst_ready),
      .misalign_fault(misalign_fault)
   );

   fetch_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RESET_PC(32'hFFFF_FFFC)
   ) dut_wrap (
      .clk           (clk),
      .nrst          (nrst),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .imem_req      (w_imem_req),
      .imem_addr     (w_imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .inst_valid    (w_inst_valid),
      .inst          (w_inst),
      .inst_pc       (w_inst_pc),
      .inst_ready    (inst_ready),
      .misalign_fault(w_misalign_fault)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic gnt, input logic ready, input logic r_en, input logic [31:0] r_addr);
      imem_gnt      = gnt;
      inst_ready    = ready;
      redirect_en   = r_en;
      redirect_addr = r_addr;
   endtask

   // Inputs change 2 time units after the rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic pushExpected(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.data = mem_word(pc);
      sb_q.push_back(e);
   endtask

   task automatic runUntilDrained(input string tag, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         nextCycle();
         n++;
      end
      checkOutput(tag, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic waitValid(input string tag, input int budget);
      int n = 0;
      while (!inst_valid && n < budget) begin
         nextCycle();
         n++;
      end
      checkOutput(tag, 32'(inst_valid), 32'd1);
   endtask

   // Memory responder: a request accepted at an edge is answered
   // resp_delay cycles after the following cycle. Reset drops it.
   always @(negedge clk) begin
      acc_now  = nrst && imem_req && imem_gnt;
      acc_addr = imem_addr;
   end

   always @(posedge clk) begin
      #1;
      imem_rvalid = 1'b0;
      if (!nrst) begin
         pend = 1'b0;
      end else begin
         if (acc_now) begin
            pend      = 1'b1;
            pend_cnt  = resp_delay;
            pend_addr = acc_addr;
         end
         if (pend) begin
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
               pend        = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (spur_req != spur_ack) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            spur_ack    = spur_req;
         end
      end
   end

   // Scoreboard monitor: every consumed instruction must match the oldest
   // expectation.
   always @(negedge clk) begin
      if (nrst && inst_valid && inst_ready && !redirect_en) begin
         checkOutput("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("inst_pc", inst_pc, mon_e.pc);
            checkOutput("inst", inst, mon_e.data);
         end
      end
   end

   // Record the first two accepted addresses and first instruction of the
   // wrap instance.
   always @(negedge clk) begin
      if (nrst && w_imem_req && imem_gnt && w_log_cnt < 2) begin
         w_addr_log[w_log_cnt] = w_imem_addr;
         w_log_cnt++;
      end
      if (nrst && w_inst_valid && !w_first_seen) begin
         w_first_seen = 1'b1;
         w_first_pc   = w_inst_pc;
         w_first_inst = w_inst;
      end
      if (w_misalign_fault) w_fault_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      nrst = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #3;
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_misalign", 32'(misalign_fault), 32'd0);

      // Release: request in the first cycle, sequential fetch 0x0, 0x4, 0x8
      @(posedge clk);
      #2;
      nrst = 1'b1;
      #1;
      checkOutput("req_after_release", 32'(imem_req), 32'd1);
      checkOutput("first_addr", imem_addr, 32'h0);
      checkOutput("wrap_first_addr", w_imem_addr, 32'hFFFF_FFFC);
      pushExpected(32'h0);
      pushExpected(32'h4);
      pushExpected(32'h8);
      runUntilDrained("seq_drain", 40);

      checkOutput("wrap_log_cnt", 32'(w_log_cnt), 32'd2);
      checkOutput("wrap_addr0", w_addr_log[0], 32'hFFFF_FFFC);
      checkOutput("wrap_addr1", w_addr_log[1], 32'h0000_0000);
      checkOutput("wrap_first_pc", w_first_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_first_inst", w_first_inst, mem_word(32'h0));

      // Decode stalls for 5 cycles on the instruction at 0xC
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("next_fetch_c", imem_addr, 32'hC);
      waitValid("hold_valid", 10);
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         checkOutput("hold_pc", inst_pc, 32'hC);
         checkOutput("hold_inst", inst, mem_word(32'hC));
         checkOutput("hold_req", 32'(imem_req), 32'd0);
         checkOutput("hold_valid_stable", 32'(inst_valid), 32'd1);
      end
      pushExpected(32'hC);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      runUntilDrained("hold_drain", 10);
      checkOutput("after_hold_req", 32'(imem_req), 32'd1);
      checkOutput("after_hold_addr", imem_addr, 32'h10);

      // Redirect in the same cycle as the grant: old response discarded
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("drop_req", 32'(imem_req), 32'd0);
      nextCycle();
      checkOutput("redir_req", 32'(imem_req), 32'd1);
      checkOutput("redir_addr", imem_addr, 32'h100);
      pushExpected(32'h100);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      runUntilDrained("redir_drain", 20);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("after_redir_addr", imem_addr, 32'h104);

      // Redirect while holding with ready high: redirect wins
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      waitValid("hold2_valid", 10);
      checkOutput("hold2_pc", inst_pc, 32'h104);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("hold_flush_valid", 32'(inst_valid), 32'd0);
      checkOutput("hold_flush_addr", imem_addr, 32'h200);
      pushExpected(32'h200);
      runUntilDrained("hold_flush_drain", 20);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

      // PC wrap from the top of the address space
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
      pushExpected(32'hFFFF_FFFC);
      pushExpected(32'h0000_0000);
      runUntilDrained("wrap_drain", 30);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_next_addr", imem_addr, 32'h4);

      // Slow response: redirect in WAIT, then again in DROP (latest wins)
      resp_delay = 2;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h300);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h500);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("drop_wait_req", 32'(imem_req), 32'd0);
      nextCycle();
      checkOutput("latest_req", 32'(imem_req), 32'd1);
      checkOutput("latest_addr", imem_addr, 32'h500);
      resp_delay = 0;
      pushExpected(32'h500);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      runUntilDrained("latest_drain", 20);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

      // Unsolicited response while in FETCH is ignored
      spur_req++;
      nextCycle();
      nextCycle();
      checkOutput("spur_req", 32'(imem_req), 32'd1);
      checkOutput("spur_valid", 32'(inst_valid), 32'd0);
      checkOutput("spur_addr", imem_addr, 32'h504);

      // Misaligned redirect target
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      checkOutput("fault_set", 32'(misalign_fault), 32'd1);
      checkOutput("fault_req", 32'(imem_req), 32'd0);
      checkOutput("fault_valid", 32'(inst_valid), 32'd0);
      nextCycle();
      nextCycle();
      checkOutput("fault_held", 32'(misalign_fault), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h104);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("fault_clear", 32'(misalign_fault), 32'd0);
      checkOutput("fault_recover_addr", imem_addr, 32'h104);
      pushExpected(32'h104);
`else
      checkOutput("align_fault_low", 32'(misalign_fault), 32'd0);
      checkOutput("align_req", 32'(imem_req), 32'd1);
      checkOutput("align_addr", imem_addr, 32'h100);
      pushExpected(32'h100);
      pushExpected(32'h104);
`endif
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      runUntilDrained("align_drain", 30);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("align_next_addr", imem_addr, 32'h108);

      // Misaligned redirect with a request outstanding: drain first
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h10A);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("mdrop_req", 32'(imem_req), 32'd0);
      checkOutput("mdrop_fault", 32'(misalign_fault), 32'd0);
      nextCycle();
`ifdef FETCH_MISALIGN_CHECK_EN
      checkOutput("mdrop_fault_after", 32'(misalign_fault), 32'd1);
      checkOutput("mdrop_req_after", 32'(imem_req), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h108);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
`else
      checkOutput("mdrop_fault_after", 32'(misalign_fault), 32'd0);
`endif
      checkOutput("mdrop_recover_req", 32'(imem_req), 32'd1);
      checkOutput("mdrop_recover_addr", imem_addr, 32'h108);
      checkOutput("wrap_inst_no_fault", 32'(w_fault_seen), 32'(misalign_fault_seen_expected()));

      // Reset in the middle of a transaction
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      nextCycle();
      nrst = 1'b0;
      #1;
      checkOutput("mid_rst_req", 32'(imem_req), 32'd0);
      checkOutput("mid_rst_valid", 32'(inst_valid), 32'd0);
      checkOutput("mid_rst_fault", 32'(misalign_fault), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      nextCycle();
      nextCycle();
      checkOutput("mid_rst_inst_pc", inst_pc, 32'h0);
      checkOutput("mid_rst_inst", inst, 32'h0);
      nrst = 1'b1;
      #1;
      checkOutput("rerelease_req", 32'(imem_req), 32'd1);
      checkOutput("rerelease_addr", imem_addr, 32'h0);
      pushExpected(32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      runUntilDrained("rerelease_drain", 20);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

   // The wrap instance sees the same misaligned redirects as the main one,
   // so it should have entered FAULT only when the check is built in.
   function automatic logic misalign_fault_seen_expected();
`ifdef FETCH_MISALIGN_CHECK_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

endmodule
